// File: rtl/direct_cache_wt.sv
// Direct-mapped write-through read cache between the CPU bus and a 16-bit SDRAM port.
// Critical-word-first line fill with wrap; write hits merge bytes, writes never allocate.
module direct_cache_wt #(
  parameter int CACHEBITS = 11,
  parameter int LINEBITS  = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ready,
  input  logic        flush,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [3:0]  bytesel,
  input  logic [31:0] data_from_cpu,
  output logic [31:0] data_to_cpu,
  output logic        cpu_ack,
  output logic        busy,
  output logic [31:0] sdram_addr,
  output logic        sdram_req,
  output logic        sdram_rw,
  output logic [31:0] sdram_wdata,
  output logic [3:0]  sdram_bytesel,
  input  logic        sdram_ack,
  input  logic        sdram_fill,
  input  logic [15:0] data_from_sdram
);

  localparam int IW = CACHEBITS - LINEBITS;
  localparam int TW = 30 - CACHEBITS;
  localparam int TD = 1 << IW;
  localparam int DD = 1 << CACHEBITS;

  typedef enum logic [2:0] {
    S_INIT, S_FLUSH, S_IDLE,
    S_LOOKUP, S_FILL, S_WRITE
  } state_t;

  state_t r_state, w_next;

  logic [31:0]         r_addr;
  logic                r_rw;
  logic [31:0]         r_wdata;
  logic [3:0]          r_bsel;
  logic                r_fp;
  logic [IW-1:0]       r_fcnt;
  logic [LINEBITS-1:0] r_cnt;
  logic [LINEBITS-1:0] r_wcnt;
  logic                r_half;
  logic [15:0]         r_hi;
  logic                r_ready;
  logic                r_ack;
  logic                r_busy;
  logic                r_sreq;
  logic                r_srw;
  logic [31:0]         r_saddr;
  logic [31:0]         r_rdata;

  logic [TW:0]   r_tag_mem [TD];
  logic [TW:0]   r_tag_q;
  logic [31:0]   r_dat_mem [DD];
  logic [31:0]   r_dat_q;

  logic [IW-1:0]        w_tag_a;
  logic                 w_tag_we;
  logic [TW:0]          w_tag_wd;
  logic [CACHEBITS-1:0] w_dat_a;
  logic                 w_dat_we;
  logic [31:0]          w_dat_wd;
  logic [31:0]          w_merged;
  logic [TW-1:0]        w_ltag;
  logic                 w_hit;
  logic                 w_accept;
  logic                 w_fill_wr;
  logic                 w_last;

  assign w_ltag    = r_addr[31:CACHEBITS+2];
  assign w_hit     = r_tag_q[TW] &&
                     (r_tag_q[TW-1:0] == w_ltag);
  assign w_accept  = cpu_req && r_ready && !r_ack;
  assign w_fill_wr = (r_state == S_FILL) &&
                     sdram_fill && r_half;
  assign w_last    = &r_wcnt;

  always_comb begin
    for (int i = 0; i < 4; i++)
      w_merged[8*i +: 8] = r_bsel[i] ?
        r_wdata[8*i +: 8] : r_dat_q[8*i +: 8];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_INIT;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_INIT:  w_next = S_FLUSH;
      S_FLUSH: if (&r_fcnt) w_next = S_IDLE;
      S_IDLE: begin
        if (r_fp)          w_next = S_FLUSH;
        else if (w_accept) w_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (!r_rw)      w_next = S_WRITE;
        else if (w_hit) w_next = S_IDLE;
        else            w_next = S_FILL;
      end
      S_FILL:  if (w_fill_wr && w_last) w_next = S_IDLE;
      S_WRITE: if (sdram_ack) w_next = S_IDLE;
      default: w_next = S_INIT;
    endcase
  end

  // RAM addressing: IDLE looks up the incoming address, later states the latched one
  always_comb begin
    w_tag_a  = cpu_addr[CACHEBITS+1:LINEBITS+2];
    w_tag_we = 1'b0;
    w_tag_wd = '0;
    w_dat_a  = cpu_addr[CACHEBITS+1:2];
    w_dat_we = 1'b0;
    w_dat_wd = w_merged;
    unique case (r_state)
      S_FLUSH: begin
        w_tag_a  = r_fcnt;
        w_tag_we = 1'b1;
      end
      S_LOOKUP: begin
        w_tag_a  = r_addr[CACHEBITS+1:LINEBITS+2];
        w_tag_we = r_rw && !w_hit;
        w_tag_wd = {1'b1, w_ltag};
        w_dat_a  = r_addr[CACHEBITS+1:2];
        w_dat_we = !r_rw && w_hit;
      end
      S_FILL: begin
        w_dat_a  = {r_addr[CACHEBITS+1:LINEBITS+2], r_cnt};
        w_dat_we = w_fill_wr;
        w_dat_wd = {r_hi, data_from_sdram};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_tag_we) r_tag_mem[w_tag_a] <= w_tag_wd;
    r_tag_q <= r_tag_mem[w_tag_a];
  end

  always_ff @(posedge clk) begin
    if (w_dat_we) r_dat_mem[w_dat_a] <= w_dat_wd;
    r_dat_q <= r_dat_mem[w_dat_a];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fp   <= 1'b0;
      r_fcnt <= '0;
    end else begin
      r_fp <= flush || (r_fp && !(w_next == S_FLUSH &&
                                  r_state != S_FLUSH));
      if (r_state == S_FLUSH) r_fcnt <= r_fcnt + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr  <= '0;
      r_rw    <= 1'b0;
      r_wdata <= '0;
      r_bsel  <= '0;
      r_cnt   <= '0;
      r_wcnt  <= '0;
      r_half  <= 1'b0;
      r_hi    <= '0;
      r_ready <= 1'b0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_sreq  <= 1'b0;
      r_srw   <= 1'b0;
      r_saddr <= '0;
      r_rdata <= '0;
    end else begin
      r_ack   <= 1'b0;
      r_ready <= (w_next != S_INIT) && (w_next != S_FLUSH);
      r_busy  <= (w_next != S_IDLE);
      unique case (r_state)
        S_IDLE: if (w_next == S_LOOKUP) begin
          r_addr  <= cpu_addr;
          r_rw    <= cpu_rw;
          r_wdata <= data_from_cpu;
          r_bsel  <= bytesel;
        end
        S_LOOKUP: begin
          r_cnt  <= r_addr[LINEBITS+1:2];
          r_wcnt <= '0;
          r_half <= 1'b0;
          if (r_rw && w_hit) begin
            r_ack   <= 1'b1;
            r_rdata <= r_dat_q;
          end else begin
            r_sreq  <= 1'b1;
            r_srw   <= r_rw;
            r_saddr <= r_rw ? {r_addr[31:2], 2'b00} : r_addr;
          end
        end
        S_FILL: if (sdram_fill) begin
          r_sreq <= 1'b0;
          r_half <= !r_half;
          if (!r_half) begin
            r_hi <= data_from_sdram;
          end else begin
            r_cnt  <= r_cnt + LINEBITS'(1);
            r_wcnt <= r_wcnt + LINEBITS'(1);
            // forward the critical word as soon as it is complete
            if (r_wcnt == '0) begin
              r_ack   <= 1'b1;
              r_rdata <= {r_hi, data_from_sdram};
            end
          end
        end
        S_WRITE: if (sdram_ack) begin
          r_sreq <= 1'b0;
          r_ack  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ready         = r_ready;
  assign cpu_ack       = r_ack;
  assign busy          = r_busy;
  assign data_to_cpu   = r_rdata;
  assign sdram_req     = r_sreq;
  assign sdram_rw      = r_srw;
  assign sdram_addr    = r_saddr;
  assign sdram_wdata   = r_wdata;
  assign sdram_bytesel = r_bsel;

endmodule

// File: tb/tb_direct_cache_wt.sv
// Bench for direct_cache_wt: directed vector table, flush-during-fill
// sequence and random traffic against a line-tag and memory reference.
module tb_direct_cache_wt;

  localparam int CB = 11;
  localparam int LB = 2;
  localparam int LW = 1 << LB;
  localparam int TD = 1 << (CB - LB);

  logic        clk;
  logic        rst_n;
  logic        ready;
  logic        flush;
  logic [31:0] cpu_addr;
  logic        cpu_req;
  logic        cpu_rw;
  logic [3:0]  bytesel;
  logic [31:0] data_from_cpu;
  logic [31:0] data_to_cpu;
  logic        cpu_ack;
  logic        busy;
  logic [31:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_rw;
  logic [31:0] sdram_wdata;
  logic [3:0]  sdram_bytesel;
  logic        sdram_ack;
  logic        sdram_fill;
  logic [15:0] data_from_sdram;

  direct_cache_wt #(.CACHEBITS(CB), .LINEBITS(LB)) dut (
    .clk(clk), .reset(rst_n), .ready(ready), .flush(flush),
    .cpu_addr(cpu_addr), .cpu_req(cpu_req), .cpu_rw(cpu_rw),
    .bytesel(bytesel), .data_from_cpu(data_from_cpu),
    .data_to_cpu(data_to_cpu), .cpu_ack(cpu_ack), .busy(busy),
    .sdram_addr(sdram_addr), .sdram_req(sdram_req),
    .sdram_rw(sdram_rw), .sdram_wdata(sdram_wdata),
    .sdram_bytesel(sdram_bytesel), .sdram_ack(sdram_ack),
    .sdram_fill(sdram_fill), .data_from_sdram(data_from_sdram)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  bit aborted = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // backing stores: sd_mem is what the SDRAM holds, ref_mem what it should hold
  logic [31:0] sd_mem  [bit [31:0]];
  logic [31:0] ref_mem [bit [31:0]];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, ~a[17:2]};
  endfunction

  function automatic logic [31:0] sd_rd(input logic [31:0] a);
    return sd_mem.exists(a) ? sd_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o,
      input logic [31:0] n, input logic [3:0] bs);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = bs[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  // line-level cache model: which tag each line index holds
  bit          mv [TD];
  logic [18:0] mt [TD];

  function automatic bit model_miss(input bit rw,
                                    input logic [31:0] a);
    int idx;
    bit hit;
    idx = int'(a[CB+1:LB+2]);
    if (!rw) return 1'b0;
    hit = mv[idx] && (mt[idx] == a[31:CB+2]);
    mv[idx] = 1'b1;
    mt[idx] = a[31:CB+2];
    return !hit;
  endfunction

  function automatic void model_flush();
    for (int i = 0; i < TD; i++) mv[i] = 1'b0;
  endfunction

  // SDRAM responder
  int n_bursts = 0;
  int n_writes = 0;
  logic [31:0] last_raddr, last_waddr, last_wdata;
  logic [3:0]  last_wbs;
  logic [31:0] rsp_a, rsp_w;

  initial begin
    sdram_fill = 0;
    sdram_ack  = 0;
    data_from_sdram = '0;
    forever begin
      @(negedge clk);
      if (rst_n && sdram_req) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if (sdram_rw) begin
          n_bursts++;
          last_raddr = sdram_addr;
          for (int i = 0; i < LW; i++) begin
            rsp_a = (last_raddr & ~32'(LW * 4 - 1)) |
                    32'((((last_raddr >> 2) + i) % LW) << 2);
            rsp_w = sd_rd(rsp_a);
            sdram_fill = 1;
            data_from_sdram = rsp_w[31:16];
            @(negedge clk);
            data_from_sdram = rsp_w[15:0];
            @(negedge clk);
          end
          sdram_fill = 0;
        end else begin
          n_writes++;
          last_waddr = sdram_addr;
          last_wdata = sdram_wdata;
          last_wbs   = sdram_bytesel;
          sd_mem[sdram_addr] = merge(sd_rd(sdram_addr),
                                     sdram_wdata, sdram_bytesel);
          sdram_ack = 1;
          @(negedge clk);
          sdram_ack = 0;
        end
      end
    end
  end

  task automatic cpu_op(input bit rw, input logic [31:0] a,
      input logic [31:0] wd, input logic [3:0] bs,
      input bit wait_idle, input int flush_at,
      output logic [31:0] rd, output int cyc,
      output int nb, output int nw, output int nlow);
    int b0, w0, guard;
    rd = '0; cyc = 0; nlow = 0; guard = 0;
    @(negedge clk);
    if (wait_idle)
      while ((busy || !ready) && guard < 3000) begin
        @(negedge clk);
        guard++;
      end
    b0 = n_bursts;
    w0 = n_writes;
    cpu_req = 1; cpu_rw = rw; cpu_addr = a;
    data_from_cpu = wd; bytesel = bs;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      flush = (cyc == flush_at);
      if (!ready) nlow++;
      if (cpu_ack) break;
    end
    flush = 0;
    checks++;
    if (!cpu_ack) begin
      fails++;
      aborted = 1;
      $display("FAIL ack timeout: addr %h no cpu_ack in %0d cycles",
               a, cyc);
    end
    rd = data_to_cpu;
    cpu_req = 0;
    nb = n_bursts - b0;
    nw = n_writes - w0;
  endtask

  task automatic do_check(input string nm, input bit rw,
      input logic [31:0] a, input logic [31:0] wd,
      input logic [3:0] bs, input logic [31:0] exp_rd,
      input bit exp_miss, input bit wait_idle,
      input int flush_at, output int nlow);
    logic [31:0] rd;
    int cyc, nb, nw;
    cpu_op(rw, a, wd, bs, wait_idle, flush_at, rd, cyc, nb, nw, nlow);
    if (aborted) return;
    chk({nm, " bursts"}, nb, {31'd0, exp_miss});
    if (rw) begin
      chk({nm, " rdata"}, rd, exp_rd);
      if (exp_miss) chk({nm, " burst addr"}, last_raddr,
                        {a[31:2], 2'b00});
      else          chk({nm, " hit latency"}, cyc, 2);
    end else begin
      chk({nm, " sdram writes"}, nw, 1);
      chk({nm, " waddr"}, last_waddr, a);
      chk({nm, " wdata"}, last_wdata, wd);
      chk({nm, " wbytesel"}, {28'd0, last_wbs}, {28'd0, bs});
    end
  endtask

  typedef struct {
    bit          rw;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  bs;
    logic [31:0] exp;
    bit          miss;
  } vec_t;

  vec_t vt [14];

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    sd_mem[a]  = d;
    ref_mem[a] = d;
  endtask

  initial begin
    int n, nlow;
    bit m;
    logic [31:0] a, wd, e;
    logic [3:0] bs;
    bit rw;

    vt[0]  = '{1'b1, 32'h100,  32'h0, 4'h0, 32'h5555_6666, 1'b1};
    vt[1]  = '{1'b1, 32'h2100, 32'h0, 4'h0, 32'hCAFE_0100, 1'b1};
    vt[2]  = '{1'b1, 32'h108,  32'h0, 4'h0, 32'h1111_2222, 1'b1};
    vt[3]  = '{1'b1, 32'h100,  32'h0, 4'h0, 32'h5555_6666, 1'b0};
    vt[4]  = '{1'b1, 32'h104,  32'h0, 4'h0, 32'h7777_8888, 1'b0};
    vt[5]  = '{1'b1, 32'h10C,  32'h0, 4'h0, 32'h3333_4444, 1'b0};
    vt[6]  = '{1'b0, 32'h108,  32'hAABB_CCDD, 4'h3, 32'h0, 1'b0};
    vt[7]  = '{1'b1, 32'h108,  32'h0, 4'h0, 32'h1111_CCDD, 1'b0};
    vt[8]  = '{1'b0, 32'h4000, 32'h1234_5678, 4'hF, 32'h0, 1'b0};
    vt[9]  = '{1'b1, 32'h4000, 32'h0, 4'h0, 32'h1234_5678, 1'b1};
    vt[10] = '{1'b0, 32'h10C,  32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0};
    vt[11] = '{1'b1, 32'h10C,  32'h0, 4'h0, 32'h3333_4444, 1'b0};
    vt[12] = '{1'b1, 32'h2108, 32'h0, 4'h0, 32'hCAFE_0108, 1'b1};
    vt[13] = '{1'b1, 32'h108,  32'h0, 4'h0, 32'h1111_CCDD, 1'b1};

    preload(32'h100, 32'h5555_6666);
    preload(32'h104, 32'h7777_8888);
    preload(32'h108, 32'h1111_2222);
    preload(32'h10C, 32'h3333_4444);
    for (int i = 0; i < 4; i++)
      preload(32'h2100 + 32'(4 * i), 32'hCAFE_0100 + 32'(4 * i));

    rst_n = 0; flush = 0; cpu_req = 0; cpu_rw = 0;
    cpu_addr = '0; bytesel = '0; data_from_cpu = '0;
    model_flush();
    repeat (3) @(negedge clk);
    chk("reset ready", {31'd0, ready}, 0);
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset cpu_ack", {31'd0, cpu_ack}, 0);
    chk("reset sdram_req", {31'd0, sdram_req}, 0);
    chk("reset sdram_addr", sdram_addr, 0);
    chk("reset data_to_cpu", data_to_cpu, 0);
    rst_n = 1;
    n = 0;
    while (!ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("init ready latency ok", {31'd0, n >= TD && n <= TD + 2}, 1);

    for (int i = 0; i < 14 && !aborted; i++) begin
      m = model_miss(vt[i].rw, vt[i].a);
      do_check($sformatf("vec%0d", i), vt[i].rw, vt[i].a,
               vt[i].wd, vt[i].bs, vt[i].exp, vt[i].miss,
               1'b1, 0, nlow);
      if (!vt[i].rw)
        ref_mem[vt[i].a] = merge(ref_rd(vt[i].a), vt[i].wd, vt[i].bs);
    end

    // flush pulse mid-fill, next read queued behind the flush
    if (!aborted) begin
      a = 32'h2204;
      m = model_miss(1'b1, a);
      do_check("flushfill first", 1'b1, a, 0, 0, ref_rd(a), m,
               1'b1, 3, nlow);
      model_flush();
      m = model_miss(1'b1, a);
      do_check("flushfill queued", 1'b1, a, 0, 0, ref_rd(a), m,
               1'b0, 0, nlow);
      chk("flush ready low cycles", {31'd0, nlow >= TD}, 1);
    end

    for (int i = 0; i < 300 && !aborted; i++) begin
      a = 32'h0001_0000 | 32'($urandom_range(0, 3) << 13) |
          32'($urandom_range(0, 7) << 4) |
          32'($urandom_range(0, 3) << 2);
      rw = ($urandom_range(0, 9) < 6);
      wd = $urandom;
      bs = 4'($urandom_range(0, 15));
      e  = ref_rd(a);
      m  = model_miss(rw, a);
      do_check($sformatf("rnd%0d", i), rw, a, wd, bs, e, m,
               1'b1, 0, nlow);
      if (!rw) ref_mem[a] = merge(ref_rd(a), wd, bs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
